// File: rtl/slave_package.sv
// AHB-Lite encodings shared by the burst master, its address generator and the slave fabric.
// Also holds beat-count and address-alignment helpers used when a command is accepted.
package slave_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } HTRANS_E;

  typedef enum logic [2:0] {
    BYTE      = 3'b000,
    HALF_WORD = 3'b001,
    WORD      = 3'b010
  } HSIZE_E;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } HBURST_E;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } HRESP_E;

  localparam int unsigned KB_BOUND = 1024;

  // Undefined-length INCR uses len, with zero promoted to a single beat.
  function automatic logic [8:0] burst_beats(HBURST_E burst, logic [8:0] len);
    logic [8:0] beats;
    case (burst)
      SINGLE:         beats = 9'd1;
      WRAP4, INCR4:   beats = 9'd4;
      WRAP8, INCR8:   beats = 9'd8;
      WRAP16, INCR16: beats = 9'd16;
      INCR:           beats = (len == 9'd0) ? 9'd1 : len;
      default:        beats = 9'd1;
    endcase
    return beats;
  endfunction

  function automatic logic is_wrap(HBURST_E burst);
    return (burst == WRAP4) || (burst == WRAP8) || (burst == WRAP16);
  endfunction

  function automatic logic [31:0] align_addr(logic [31:0] addr, HSIZE_E size);
    return addr & ~((32'd1 << size) - 32'd1);
  endfunction

endpackage

// File: rtl/ahb_lite_burst_master_if.sv
// Client command/data port and AHB-Lite bus of the burst master, bundled as one interface.
// The master modport is the sequencer's view; slave is the view of the client plus fabric.
interface ahb_lite_burst_master_if;
  import slave_package::*;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  HSIZE_E      cmd_size;
  HBURST_E     cmd_burst;
  logic [8:0]  cmd_len;

  logic [31:0] wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        err;

  logic [31:0] HADDR;
  HTRANS_E     HTRANS;
  logic        HWRITE;
  HSIZE_E      HSIZE;
  HBURST_E     HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  HRESP_E      HRESP;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len,
    input  wdata, wdata_valid,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done, err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_burst, cmd_len,
    output wdata, wdata_valid,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done, err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_addr_gen.sv
// Combinational next-beat address for INCR*/WRAP* bursts, plus detection of an undefined-length
// INCR step that lands in a new KB_BOUND region (that beat must be re-issued as NONSEQ).
module ahb_addr_gen
  import slave_package::*;
#(
  parameter int unsigned KB_BOUND = slave_package::KB_BOUND
) (
  input  logic [31:0] addr,
  input  HSIZE_E      size,
  input  HBURST_E     burst,
  output logic [31:0] next_addr,
  output logic        cross_kb
);

  localparam logic [31:0] KbMask = 32'(KB_BOUND - 1);

  logic [31:0] inc;
  logic [31:0] incr_addr;
  logic [31:0] wrap_mask;

  always_comb begin
    inc       = 32'd1 << size;
    incr_addr = addr + inc;
    // Wrap window is beats * transfer size bytes; only the bits inside it advance.
    wrap_mask = (32'(burst_beats(burst, 9'd1)) << size) - 32'd1;
    if (is_wrap(burst)) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end else begin
      next_addr = incr_addr;
    end
    cross_kb = (burst == INCR) && (((addr ^ next_addr) & ~KbMask) != 32'd0);
  end

endmodule

// File: rtl/ahb_lite_burst_master.sv
// Command-driven AHB-Lite burst sequencer. wdata_ready is a registered pulse meaning the word
// presented before the previous edge was taken; the client shows its next word in that cycle.
module ahb_lite_burst_master
  import slave_package::*;
#(
  parameter int unsigned MAX_LEN  = 256,
  parameter int unsigned KB_BOUND = slave_package::KB_BOUND
) (
  input logic                     HCLK,
  input logic                     HRESET,
  ahb_lite_burst_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [8:0] MaxLenW = 9'(MAX_LEN);

  logic [1:0]  state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  HTRANS_E     htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  HSIZE_E      hsize_q, hsize_d;
  HBURST_E     hburst_q, hburst_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [8:0]  beats_left_q, beats_left_d;
  logic        dp_valid_q, dp_valid_d;
  logic        busy_nonseq_q, busy_nonseq_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        wdata_ready_q, wdata_ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [31:0] next_addr;
  logic        cross_kb;
  logic        addr_done;
  logic        data_err;
  logic        pop;
  logic [8:0]  len_clamped;

  ahb_addr_gen #(
    .KB_BOUND (KB_BOUND)
  ) u_addr_gen (
    .addr      (haddr_q),
    .size      (hsize_q),
    .burst     (hburst_q),
    .next_addr (next_addr),
    .cross_kb  (cross_kb)
  );

  assign addr_done   = bus.HREADY && ((htrans_q == NONSEQ) || (htrans_q == SEQ));
  assign data_err    = dp_valid_q && (bus.HRESP == ERROR);
  assign len_clamped = (bus.cmd_len > MaxLenW) ? MaxLenW : bus.cmd_len;

  always_comb begin
    state_d       = state_q;
    haddr_d       = haddr_q;
    htrans_d      = htrans_q;
    hwrite_d      = hwrite_q;
    hsize_d       = hsize_q;
    hburst_d      = hburst_q;
    hwdata_d      = hwdata_q;
    wbuf_d        = wbuf_q;
    beats_left_d  = beats_left_q;
    dp_valid_d    = dp_valid_q;
    busy_nonseq_d = busy_nonseq_q;
    cmd_ready_d   = cmd_ready_q;
    rdata_d       = rdata_q;
    wdata_ready_d = 1'b0;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    pop           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && (!bus.cmd_write || bus.wdata_valid)) begin
          state_d      = S_ADDR;
          cmd_ready_d  = 1'b0;
          htrans_d     = NONSEQ;
          haddr_d      = align_addr(bus.cmd_addr, bus.cmd_size);
          hwrite_d     = bus.cmd_write;
          hsize_d      = bus.cmd_size;
          hburst_d     = bus.cmd_burst;
          beats_left_d = burst_beats(bus.cmd_burst, len_clamped) - 9'd1;
          dp_valid_d   = 1'b0;
          pop          = bus.cmd_write;
        end
      end

      S_ADDR, S_LAST: begin
        if (data_err) begin
          // First ERROR cycle: cancel the pending beat by going IDLE right away.
          htrans_d   = IDLE;
          dp_valid_d = 1'b0;
          state_d    = S_ERR;
        end else if (bus.HREADY) begin
          if (dp_valid_q && !hwrite_q) begin
            rdata_d       = bus.HRDATA;
            rdata_valid_d = 1'b1;
          end
          dp_valid_d = addr_done;
          if (state_q == S_LAST) begin
            done_d      = 1'b1;
            cmd_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else if (addr_done) begin
            if (hwrite_q) begin
              hwdata_d = wbuf_q;
            end
            if (beats_left_q == 9'd0) begin
              htrans_d = IDLE;
              state_d  = S_LAST;
            end else begin
              haddr_d      = next_addr;
              beats_left_d = beats_left_q - 9'd1;
              if (hwrite_q && !bus.wdata_valid) begin
                htrans_d      = BUSY;
                busy_nonseq_d = cross_kb;
              end else begin
                if (cross_kb) begin
                  htrans_d = NONSEQ;
                end else begin
                  htrans_d = SEQ;
                end
                pop = hwrite_q;
              end
            end
          end else if ((htrans_q == BUSY) && bus.wdata_valid) begin
            // Address already advanced on entry to BUSY; just release the held beat.
            if (busy_nonseq_q) begin
              htrans_d = NONSEQ;
            end else begin
              htrans_d = SEQ;
            end
            pop = 1'b1;
          end
        end
      end

      S_ERR: begin
        if (bus.HREADY) begin
          err_d       = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      wbuf_d        = bus.wdata;
      wdata_ready_d = 1'b1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q       <= S_IDLE;
      haddr_q       <= 32'd0;
      htrans_q      <= IDLE;
      hwrite_q      <= 1'b0;
      hsize_q       <= BYTE;
      hburst_q      <= SINGLE;
      hwdata_q      <= 32'd0;
      wbuf_q        <= 32'd0;
      beats_left_q  <= 9'd0;
      dp_valid_q    <= 1'b0;
      busy_nonseq_q <= 1'b0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      haddr_q       <= haddr_d;
      htrans_q      <= htrans_d;
      hwrite_q      <= hwrite_d;
      hsize_q       <= hsize_d;
      hburst_q      <= hburst_d;
      hwdata_q      <= hwdata_d;
      wbuf_q        <= wbuf_d;
      beats_left_q  <= beats_left_d;
      dp_valid_q    <= dp_valid_d;
      busy_nonseq_q <= busy_nonseq_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.HADDR       = haddr_q;
  assign bus.HTRANS      = htrans_q;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HSIZE       = hsize_q;
  assign bus.HBURST      = hburst_q;
  assign bus.HWDATA      = hwdata_q;
  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.wdata_ready = wdata_ready_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ahb_lite_burst_master.sv
// Directed bench for the AHB-Lite burst master: per-cycle bus traces against hand-computed
// tables, with the bench acting as both the local client and the slave fabric.
module tb_ahb_lite_burst_master;
  import slave_package::*;

  logic HCLK = 1'b0;
  logic HRESET;

  ahb_lite_burst_master_if bus ();

  ahb_lite_burst_master #(
    .MAX_LEN  (256),
    .KB_BOUND (1024)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;

  int checks   = 0;
  int failures = 0;

  logic [31:0] words [16];
  int wp = 0;
  int wn = 0;
  int stall_at = -1;
  int stall_left = 0;
  int rv_count, done_count, err_count, wr_count;

  string t1 = "NSSSI";
  string t3 = "NSBBSSSSSSI";
  string t4 = "NSNSI";
  logic [31:0] a1 [4]  = '{32'h100, 32'h104, 32'h108, 32'h10C};
  logic [31:0] a2 [4]  = '{32'h038, 32'h03C, 32'h030, 32'h034};
  logic [31:0] a3 [16] = '{32'h200, 32'h202, 32'h204, 32'h204, 32'h204, 32'h206, 32'h208,
                           32'h20A, 32'h20C, 32'h20E, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] a4 [4]  = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tr_code(input byte ch);
    case (ch)
      "N":     return 32'd2;
      "S":     return 32'd3;
      "B":     return 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  // One clock; then the client reacts to wdata_ready and tallies output pulses.
  task automatic step();
    @(posedge HCLK);
    #1;
    if (bus.wdata_ready) begin
      wp++;
      wr_count++;
    end
    if (bus.rdata_valid) rv_count++;
    if (bus.done) done_count++;
    if (bus.err) err_count++;
    bus.wdata = words[wp[3:0]];
    if (wp == stall_at && stall_left > 0) begin
      bus.wdata_valid = 1'b0;
      stall_left--;
    end else begin
      bus.wdata_valid = (wp < wn);
    end
  endtask

  task automatic load_words(input int n, input logic [31:0] base);
    for (int i = 0; i < 16; i++) words[i] = base + 32'(i);
    wn = n;
    wp = 0;
    bus.wdata       = words[0];
    bus.wdata_valid = (n > 0);
  endtask

  task automatic issue(input logic [31:0] addr, input logic wr, input HSIZE_E size,
                       input HBURST_E burst, input logic [8:0] len);
    bus.cmd_addr  = addr;
    bus.cmd_write = wr;
    bus.cmd_size  = size;
    bus.cmd_burst = burst;
    bus.cmd_len   = len;
    bus.cmd_valid = 1'b1;
    rv_count   = 0;
    done_count = 0;
    err_count  = 0;
    wr_count   = 0;
    step();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    HRESET          = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_addr    = 32'd0;
    bus.cmd_write   = 1'b0;
    bus.cmd_size    = BYTE;
    bus.cmd_burst   = SINGLE;
    bus.cmd_len     = 9'd0;
    bus.wdata       = 32'd0;
    bus.wdata_valid = 1'b0;
    bus.HRDATA      = 32'd0;
    bus.HREADY      = 1'b1;
    bus.HRESP       = OKAY;
    load_words(0, 32'd0);
    step();
    step();

    check_eq("rst htrans", 32'(bus.HTRANS), 32'd0);
    check_eq("rst haddr", bus.HADDR, 32'd0);
    check_eq("rst hsize", 32'(bus.HSIZE), 32'd0);
    check_eq("rst hburst", 32'(bus.HBURST), 32'd0);
    check_eq("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_eq("rst wdata_ready", 32'(bus.wdata_ready), 32'd0);
    check_eq("rst done_err", 32'({bus.done, bus.err, bus.rdata_valid}), 32'd0);
    HRESET = 1'b0;
    step();

    // Read INCR4 WORD @0x100, zero wait states.
    issue(32'h100, 1'b0, WORD, INCR4, 9'd0);
    for (int c = 1; c <= 6; c++) begin
      bus.HRDATA = 32'hA000_0000 + 32'(c);
      if (c <= 5) check_eq($sformatf("t1 htrans c%0d", c), 32'(bus.HTRANS), tr_code(t1[c-1]));
      if (c <= 4) check_eq($sformatf("t1 haddr c%0d", c), bus.HADDR, a1[2'(c-1)]);
      if (c >= 3) begin
        check_eq($sformatf("t1 rvalid c%0d", c), 32'(bus.rdata_valid), 32'd1);
        check_eq($sformatf("t1 rdata c%0d", c), bus.rdata, 32'hA000_0000 + 32'(c - 1));
      end
      check_eq($sformatf("t1 done c%0d", c), 32'(bus.done), 32'(c == 6));
      check_eq($sformatf("t1 cmd_ready c%0d", c), 32'(bus.cmd_ready), 32'(c == 6));
      if (c < 6) step();
    end
    check_eq("t1 rvalid count", 32'(rv_count), 32'd4);

    // Write WRAP4 WORD @0x38.
    load_words(4, 32'hC0DE_0000);
    issue(32'h38, 1'b1, WORD, WRAP4, 9'd0);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 5) check_eq($sformatf("t2 htrans c%0d", c), 32'(bus.HTRANS), tr_code(t1[c-1]));
      if (c <= 4) check_eq($sformatf("t2 haddr c%0d", c), bus.HADDR, a2[2'(c-1)]);
      if (c >= 2 && c <= 5) check_eq($sformatf("t2 hwdata c%0d", c), bus.HWDATA, words[4'(c-2)]);
      check_eq($sformatf("t2 done c%0d", c), 32'(bus.done), 32'(c == 6));
      if (c < 6) step();
    end
    check_eq("t2 wdata_ready count", 32'(wr_count), 32'd4);

    // Write INCR8 HALF_WORD @0x201 with a two-cycle data stall before beat 3.
    load_words(8, 32'hBEEF_0000);
    stall_at   = 2;
    stall_left = 2;
    issue(32'h201, 1'b1, HALF_WORD, INCR8, 9'd0);
    check_eq("t3 hsize", 32'(bus.HSIZE), 32'd1);
    for (int c = 1; c <= 12; c++) begin
      if (c <= 11) check_eq($sformatf("t3 htrans c%0d", c), 32'(bus.HTRANS), tr_code(t3[c-1]));
      if (c <= 10) check_eq($sformatf("t3 haddr c%0d", c), bus.HADDR, a3[4'(c-1)]);
      if (c == 2 || c == 3) check_eq($sformatf("t3 hwdata c%0d", c), bus.HWDATA, words[4'(c-2)]);
      if (c >= 6 && c <= 11) check_eq($sformatf("t3 hwdata c%0d", c), bus.HWDATA, words[4'(c-4)]);
      check_eq($sformatf("t3 done c%0d", c), 32'(bus.done), 32'(c == 12));
      if (c < 12) step();
    end
    check_eq("t3 wdata_ready count", 32'(wr_count), 32'd8);
    stall_at = -1;

    // Undefined INCR of 4 words straddling the 1KB boundary.
    load_words(0, 32'd0);
    issue(32'h3F8, 1'b0, WORD, INCR, 9'd4);
    for (int c = 1; c <= 6; c++) begin
      if (c <= 5) check_eq($sformatf("t4 htrans c%0d", c), 32'(bus.HTRANS), tr_code(t4[c-1]));
      if (c <= 4) check_eq($sformatf("t4 haddr c%0d", c), bus.HADDR, a4[2'(c-1)]);
      if (c == 3) check_eq("t4 hburst", 32'(bus.HBURST), 32'd1);
      check_eq($sformatf("t4 done c%0d", c), 32'(bus.done), 32'(c == 6));
      if (c < 6) step();
    end

    // Read INCR8 @0x40, slave answers ERROR on beat 2.
    issue(32'h40, 1'b0, WORD, INCR8, 9'd0);
    for (int c = 1; c <= 6; c++) begin
      bus.HRDATA = 32'hB000_0000 + 32'(c);
      bus.HREADY = (c != 3);
      bus.HRESP  = (c == 3 || c == 4) ? ERROR : OKAY;
      if (c <= 2) check_eq($sformatf("t5 htrans c%0d", c), 32'(bus.HTRANS), tr_code(t4[c-1]));
      if (c == 3) check_eq("t5 htrans c3", 32'(bus.HTRANS), 32'd3);
      if (c == 4) check_eq("t5 htrans c4", 32'(bus.HTRANS), 32'd0);
      if (c == 3) check_eq("t5 rdata", bus.rdata, 32'hB000_0002);
      check_eq($sformatf("t5 err c%0d", c), 32'(bus.err), 32'(c == 5));
      check_eq($sformatf("t5 done c%0d", c), 32'(bus.done), 32'd0);
      if (c == 5) check_eq("t5 cmd_ready", 32'(bus.cmd_ready), 32'd1);
      if (c < 6) step();
    end
    bus.HREADY = 1'b1;
    bus.HRESP  = OKAY;
    check_eq("t5 rvalid count", 32'(rv_count), 32'd1);
    check_eq("t5 done count", 32'(done_count), 32'd0);

    // Reset in the middle of an INCR16 write, then a plain SINGLE read.
    load_words(16, 32'h7700_0000);
    issue(32'h0, 1'b1, WORD, INCR16, 9'd0);
    for (int c = 1; c <= 4; c++) step();
    check_eq("t6 busy mid burst", 32'(bus.HTRANS), 32'd3);
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    load_words(0, 32'd0);
    done_count = 0;
    err_count  = 0;
    check_eq("t6 htrans after rst", 32'(bus.HTRANS), 32'd0);
    check_eq("t6 haddr after rst", bus.HADDR, 32'd0);
    check_eq("t6 cmd_ready after rst", 32'(bus.cmd_ready), 32'd1);
    check_eq("t6 wdata_ready after rst", 32'(bus.wdata_ready), 32'd0);
    for (int c = 1; c <= 3; c++) step();
    check_eq("t6 no done/err", 32'(done_count + err_count), 32'd0);

    issue(32'h84, 1'b0, WORD, SINGLE, 9'd0);
    check_eq("t6 single htrans", 32'(bus.HTRANS), 32'd2);
    check_eq("t6 single haddr", bus.HADDR, 32'h84);
    check_eq("t6 single hburst", 32'(bus.HBURST), 32'd0);
    step();
    bus.HRDATA = 32'h5A5A_1234;
    check_eq("t6 single idle", 32'(bus.HTRANS), 32'd0);
    step();
    check_eq("t6 single done", 32'(bus.done), 32'd1);
    check_eq("t6 single rvalid", 32'(bus.rdata_valid), 32'd1);
    check_eq("t6 single rdata", bus.rdata, 32'h5A5A_1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_burst_master.md
Name: ahb_lite_burst_master

Overview:
- Command-driven AHB-Lite master sequencer.
- Turns one burst command from a local client into a correctly pipelined AHB-Lite transfer sequence (NONSEQ/SEQ/BUSY/IDLE) towards the slave fabric.
- Handles HREADY wait states, write-data starvation and two-cycle ERROR responses.
- Sits between a local client (DMA/CPU port) and the slave address decoder.

Parameters:
- MAX_LEN, 256, maximum beats of an undefined-length INCR command.
- KB_BOUND, 1024, byte boundary that an INCR burst must not cross without a new NONSEQ.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  32  start byte address.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_size  in  HSIZE_E  BYTE, HALF_WORD or WORD.
- cmd_burst  in  HBURST_E  SINGLE, INCR, WRAP4/8/16, INCR4/8/16.
- cmd_len  in  9  beat count for INCR (1..MAX_LEN); ignored for fixed bursts.
- wdata  in  32  write data for the next write beat.
- wdata_valid  in  1  wdata available.
- wdata_ready  out  1  wdata consumed this cycle.
- rdata  out  32  captured read data.
- rdata_valid  out  1  one-cycle pulse per completed read beat.
- done  out  1  one-cycle pulse: burst finished with OKAY.
- err  out  1  one-cycle pulse: burst aborted by ERROR.
- HADDR  out  32  AHB address.
- HTRANS  out  HTRANS_E  AHB transfer type.
- HWRITE  out  1  AHB direction.
- HSIZE  out  HSIZE_E  AHB transfer size.
- HBURST  out  HBURST_E  AHB burst type.
- HWDATA  out  32  AHB write data.
- HRDATA  in  32  AHB read data.
- HREADY  in  1  AHB ready.
- HRESP  in  HRESP_E  AHB response.

Behaviour:
- All outputs are registered.
- Reset values: HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=BYTE, HBURST=SINGLE, HWDATA=0, cmd_ready=1, wdata_ready=0, rdata=0, rdata_valid=0, done=0, err=0, FSM=S_IDLE.
- FSM states: S_IDLE, S_ADDR (issuing beats), S_LAST (final data phase only), S_ERR (second ERROR cycle).
- S_IDLE:
  - cmd_ready=1.
  - A read is accepted on cmd_valid. A write is accepted only when cmd_valid && wdata_valid; the first wdata is popped in the same cycle.
  - Cycle N acceptance -> cycle N+1: HTRANS=NONSEQ, HADDR = cmd_addr with low bits cleared to size alignment; go to S_ADDR.
  - cmd_ready=0 from the acceptance edge until the burst ends.
- Beat counter: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16, INCR=cmd_len. cmd_len=0 is treated as 1.
- Address phase advances only on a cycle with HREADY=1. Bus outputs hold while HREADY=0.
- Next address:
  - inc = 1<<HSIZE.
  - INCR*: HADDR+inc.
  - WRAP*: (HADDR & ~(B-1)) | ((HADDR+inc) & (B-1)), where B = beats*inc.
- Undefined INCR crossing a KB_BOUND boundary: that beat is issued as NONSEQ (HBURST stays INCR); all other follow-on beats are SEQ.
- Write data: when a write beat's address phase completes, HWDATA loads the current wdata next edge and wdata_ready pulses.
  - If the next beat is due but wdata_valid=0, drive HTRANS=BUSY with HADDR already advanced; BUSY persists until wdata_valid.
  - BUSY is never driven after the last beat.
- Read data: on a cycle where a read data phase completes (HREADY=1, HRESP=OKAY), rdata<=HRDATA and rdata_valid=1 next cycle.
- After the last address phase completes: HTRANS=IDLE, go to S_LAST.
- S_LAST: when the data phase completes OKAY, done=1 next cycle, cmd_ready=1, go to S_IDLE.
- ERROR, cycle 1 (HRESP=ERROR, HREADY=0) in any data phase:
  - Next cycle HTRANS=IDLE; the pending beat is cancelled and the remaining beats are dropped.
  - No further wdata is popped; go to S_ERR.
- ERROR, cycle 2 (HREADY=1): err=1 next cycle, cmd_ready=1, go to S_IDLE. No rdata_valid is produced for the errored beat.
- HRESP=ERROR with HREADY=1 on a first cycle is treated identically: err is still produced.
- HRESET=1 at any point:
  - All outputs go to their reset values on that edge; an in-flight burst is silently dropped.
  - No done or err is produced.
- done and err are never asserted in the same cycle.

Decomposition:
- The HTRANS_E, HBURST_E, HSIZE_E and HRESP_E enums already live in slave_package; add there:
  - beat-count function burst_beats(HBURST_E, len);
  - constant KB_BOUND.
- One sub-module: ahb_addr_gen (combinational next-address, wrap and 1KB-crossing detection), instantiated once.

Test Plan:
- Read INCR4 WORD @0x100, HREADY=1 always -> HADDR 0x100/104/108/10C; HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE; 4 rdata_valid pulses; done 1 cycle after the 4th data phase.
- Write WRAP4 WORD @0x38 -> HADDR 0x38,0x3C,0x30,0x34; 4 wdata_ready pulses; HWDATA matches the pushed words.
- Write INCR8 HALF_WORD, wdata_valid dropped for 2 cycles before beat 3 -> HTRANS=BUSY for 2 cycles with HADDR=beat-3 address, then SEQ; burst completes with done.
- INCR len=4 WORD @0x3F8 -> HADDR 0x3F8(NONSEQ), 0x3FC(SEQ), 0x400(NONSEQ), 0x404(SEQ).
- Read INCR8, slave returns ERROR on beat 2 (HREADY=0 then 1) -> HTRANS=IDLE in the second cycle; err pulse; no done; only 1 rdata_valid; cmd_ready=1 afterwards.
- HRESET=1 mid-INCR16 write -> next cycle HTRANS=IDLE, cmd_ready=1, no done/err; a new SINGLE read after reset completes normally.
